serial_tx_fifo: RTL
===================

SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 Parameter CLKS_POR_BIT, default 4: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARIDADE, default 0: 0 = no parity bit, 1 = even parity bit after the data bits.
REQ-003 Port order: clock first, then reset; one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 fila_vazia  input  1  upstream FIFO empty flag; 1 = no byte available.
REQ-007 data_ent  input  8  upstream FIFO read data; valid on the cycle after ler_data is high.
REQ-008 ler_data  output  1  FIFO read strobe; a one-cycle pulse pops one byte.
REQ-009 tx_sai  output  1  serial line; idle high, LSB-first frame.
REQ-010 ocupado  output  1  1 whenever the state is not OCIOSO.
REQ-011 quadros  output  8  count of completed frames; wraps 255 -> 0.

Function
REQ-012 States: OCIOSO, LER, CAPTURA, INICIO, DADOS, PAR, PARADA; state register, bit counter, cycle counter, shift register and all outputs are flops.
REQ-013 OCIOSO: if fila_vazia=0, go to LER on the next edge; otherwise stay in OCIOSO.
REQ-014 LER: ler_data=1 for exactly this one cycle; always go to CAPTURA next. ler_data=0 in all other states.
REQ-015 CAPTURA: load data_ent into the shift register; go to INICIO. fila_vazia is ignored outside OCIOSO.
REQ-016 INICIO: tx_sai=0 for CLKS_POR_BIT cycles; then go to DADOS.
REQ-017 DADOS: tx_sai = current LSB for CLKS_POR_BIT cycles per bit; shift right after each bit.
REQ-018 DADOS exit: after 8 bits, go to PAR if PARIDADE=1, else to PARADA.
REQ-019 PAR: tx_sai = XOR of the 8 captured bits for CLKS_POR_BIT cycles; then go to PARADA.
REQ-020 PARADA: tx_sai=1 for CLKS_POR_BIT cycles; then go to OCIOSO.
REQ-021 PARADA exit: quadros increments on the same edge that enters OCIOSO.
REQ-022 tx_sai=1 in OCIOSO, LER and CAPTURA.
REQ-023 Cycle counter: counts 0..CLKS_POR_BIT-1 and resets to 0 on every bit boundary. Bit counter: 0..7.
REQ-024 Frame timing, measured from the edge entering LER (E0):
  - INICIO starts at E2.
  - Data bit i starts at E2+CLKS_POR_BIT*(1+i).
  - OCIOSO is re-entered at E2+CLKS_POR_BIT*(10+PARIDADE).
REQ-025 Back-to-back frames: with the FIFO non-empty at frame end, the next LER follows one OCIOSO cycle later. Minimum gap between stop-bit end and next start bit = 3 cycles.
REQ-026 data_ent changes outside CAPTURA shall not alter a frame in progress.

Reset
REQ-027 Reset values when rst=1 at a rising edge: state=OCIOSO, tx_sai=1, ler_data=0, ocupado=0, quadros=0, counters and shift register=0.
REQ-028 Reset in any state, including mid-frame, aborts the frame at that edge. No further ler_data until rst=0 and fila_vazia=0 is sampled in OCIOSO.
REQ-029 Reset dominates all other inputs on the same edge.

Verification (CLKS_POR_BIT=4)
REQ-030 Reset then idle: rst=1 for 2 cycles, fila_vazia=1 for 20 cycles -> tx_sai=1, ler_data=0, ocupado=0, quadros=0 throughout.
REQ-031 Single byte, PARIDADE=0: FIFO holds 0x01 -> one ler_data pulse, then:
  - tx_sai=0 for E2..E5.
  - tx_sai=1 for E6..E9.
  - tx_sai=0 for E10..E37.
  - tx_sai=1 from E38.
  - OCIOSO at E42, quadros=1.
REQ-032 Parity, PARIDADE=1: byte 0x07 -> parity bit=1 during E38..E41, stop bit E42..E45, OCIOSO at E46. Byte 0x03 -> parity bit=0.
REQ-033 Streaming: FIFO holds 1..9 back-to-back -> exactly 9 ler_data pulses, bytes decoded in order 1..9, quadros=9, each stop-to-start gap 3 cycles.
REQ-034 Abort: rst=1 for one cycle during DADOS bit 3 of byte 0xA5 -> tx_sai=1 and ocupado=0 at that edge, quadros=0. The next byte is transmitted as a complete frame.
REQ-035 Wrap: 256 consecutive frames -> quadros reads 0 after the 256th frame.

Source files
------------

// File: rtl/serial_tx_fifo.sv
// -----------------------------------------------------------------------------
// serial_tx_fifo
// Serial transmitter that pulls bytes from an upstream FIFO and sends each one
// as an LSB-first frame: a start bit (0), eight data bits, an optional even
// parity bit, and a stop bit (1). Every bit lasts CLKS_POR_BIT clock cycles.
//
// Parameters
//   CLKS_POR_BIT : clock cycles per serial bit (2..65535)
//   PARIDADE     : 0 = no parity bit, 1 = even parity bit after the data bits
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   fila_vazia in   upstream FIFO empty flag (1 = no byte available)
//   data_ent   in   upstream FIFO read data, valid the cycle after ler_data
//   ler_data   out  one-cycle FIFO pop strobe
//   tx_sai     out  serial line, idle high
//   ocupado    out  high whenever the transmitter is not idle
//   quadros    out  completed-frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module serial_tx_fifo #(
    parameter int unsigned CLKS_POR_BIT = 4,
    parameter int unsigned PARIDADE     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fila_vazia,
    input  logic [7:0] data_ent,
    output logic       ler_data,
    output logic       tx_sai,
    output logic       ocupado,
    output logic [7:0] quadros
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LER     = 3'd1,
        CAPTURA = 3'd2,
        INICIO  = 3'd3,
        DADOS   = 3'd4,
        PAR     = 3'd5,
        PARADA  = 3'd6
    } estado_t;

    localparam logic [15:0] CYC_ULTIMO = 16'(CLKS_POR_BIT - 32'd1);

    // Even parity bit of a byte: 1 when the byte has an odd number of ones.
    function automatic logic paridade_par(input logic [7:0] b);
        return ^b;
    endfunction

    estado_t     estado_q, estado_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] cyc_q, cyc_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        ler_q, ler_d;
    logic        tx_q, tx_d;
    logic        ocup_q, ocup_d;
    logic [7:0]  quadros_q, quadros_d;
    logic        fim_bit_s;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            bit_q     <= 3'd0;
            cyc_q     <= 16'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            ler_q     <= 1'b0;
            tx_q      <= 1'b1;
            ocup_q    <= 1'b0;
            quadros_q <= 8'd0;
        end else begin
            estado_q  <= estado_d;
            bit_q     <= bit_d;
            cyc_q     <= cyc_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ler_q     <= ler_d;
            tx_q      <= tx_d;
            ocup_q    <= ocup_d;
            quadros_q <= quadros_d;
        end
    end

    // Next-state and datapath logic; outputs are derived from the next state
    // so that the registered outputs line up with the state they describe.
    always_comb begin
        estado_d  = estado_q;
        bit_d     = bit_q;
        cyc_d     = cyc_q;
        shift_d   = shift_q;
        par_d     = par_q;
        quadros_d = quadros_q;
        fim_bit_s = (cyc_q == CYC_ULTIMO);

        case (estado_q)
            OCIOSO: begin
                if (!fila_vazia) begin
                    estado_d = LER;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            LER: begin
                estado_d = CAPTURA;
            end
            CAPTURA: begin
                // Byte and its parity are frozen here; data_ent is ignored
                // for the rest of the frame.
                shift_d  = data_ent;
                par_d    = paridade_par(data_ent);
                cyc_d    = 16'd0;
                bit_d    = 3'd0;
                estado_d = INICIO;
            end
            INICIO: begin
                if (fim_bit_s) begin
                    cyc_d    = 16'd0;
                    estado_d = DADOS;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            DADOS: begin
                if (fim_bit_s) begin
                    cyc_d   = 16'd0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d    = 3'd0;
                        estado_d = (PARIDADE == 32'd1) ? PAR : PARADA;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            PAR: begin
                if (fim_bit_s) begin
                    cyc_d    = 16'd0;
                    estado_d = PARADA;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            PARADA: begin
                if (fim_bit_s) begin
                    cyc_d     = 16'd0;
                    estado_d  = OCIOSO;
                    quadros_d = quadros_q + 8'd1;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ler_d  = (estado_d == LER);
        ocup_d = (estado_d != OCIOSO);

        case (estado_d)
            INICIO:  tx_d = 1'b0;
            DADOS:   tx_d = shift_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign ler_data = ler_q;
    assign tx_sai   = tx_q;
    assign ocupado  = ocup_q;
    assign quadros  = quadros_q;

endmodule
